// File: rtl/dram_arbiter.sv
// Two-core DRAM arbiter: serialises one transaction per 4 cycles (IDLE/ADDR/DATA/DONE),
// round-robin between simultaneous requesters, with saturating per-core access counters.
module dram_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [3:0]        Mem_Ctrl0,
    input  logic [ADDR_W-1:0] DAddress0,
    input  logic [DATA_W-1:0] Ddout0,
    output logic [DATA_W-1:0] Ddin0,
    output logic              dacq0,
    input  logic [3:0]        Mem_Ctrl1,
    input  logic [ADDR_W-1:0] DAddress1,
    input  logic [DATA_W-1:0] Ddout1,
    output logic [DATA_W-1:0] Ddin1,
    output logic              dacq1,
    output logic [ADDR_W-1:0] DAddress,
    output logic [DATA_W-1:0] Ddout,
    output logic              wren,
    input  logic [DATA_W-1:0] Ddin,
    output logic              owner,
    output logic [CNT_W-1:0]  acc_cnt0,
    output logic [CNT_W-1:0]  acc_cnt1
);

    typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

    state_e            state_q;
    logic              owner_q;
    logic              wr_q;
    logic              wren_q;
    logic [ADDR_W-1:0] daddr_q;
    logic [DATA_W-1:0] ddout_q;
    logic [DATA_W-1:0] ddin0_q;
    logic [DATA_W-1:0] ddin1_q;
    logic              dacq0_q;
    logic              dacq1_q;
    logic [CNT_W-1:0]  cnt0_q;
    logic [CNT_W-1:0]  cnt1_q;

    logic              req0;
    logic              req1;
    logic              grant_valid;
    logic              grant_core;
    logic              grant_wr;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_data;
    logic              unused_ctrl;

    // Bits 3:2 of the control words carry no meaning for the DRAM path.
    assign unused_ctrl = ^{Mem_Ctrl0[3:2], Mem_Ctrl1[3:2]};

    always_comb begin
        req0        = Mem_Ctrl0[0] | Mem_Ctrl0[1];
        req1        = Mem_Ctrl1[0] | Mem_Ctrl1[1];
        grant_valid = req0 | req1;
        // On contention the core that was not served last wins.
        if (req0 && req1) begin
            grant_core = ~owner_q;
        end else begin
            grant_core = req1;
        end
        grant_wr   = grant_core ? Mem_Ctrl1[1] : Mem_Ctrl0[1];
        grant_addr = grant_core ? DAddress1 : DAddress0;
        grant_data = grant_core ? Ddout1 : Ddout0;
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            owner_q <= 1'b1;
            wr_q    <= 1'b0;
            wren_q  <= 1'b0;
            daddr_q <= '0;
            ddout_q <= '0;
            ddin0_q <= '0;
            ddin1_q <= '0;
            dacq0_q <= 1'b0;
            dacq1_q <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant_valid) begin
                        owner_q <= grant_core;
                        wr_q    <= grant_wr;
                        wren_q  <= grant_wr;
                        daddr_q <= grant_addr;
                        ddout_q <= grant_data;
                        state_q <= StAddr;
                    end
                end
                StAddr: begin
                    wren_q  <= 1'b0;
                    state_q <= StData;
                end
                StData: begin
                    daddr_q <= '0;
                    ddout_q <= '0;
                    // DRAM q is valid now, one cycle after the address was presented.
                    if (!wr_q) begin
                        if (owner_q) begin
                            ddin1_q <= Ddin;
                        end else begin
                            ddin0_q <= Ddin;
                        end
                    end
                    if (owner_q) begin
                        dacq1_q <= 1'b1;
                    end else begin
                        dacq0_q <= 1'b1;
                    end
                    state_q <= StDone;
                end
                StDone: begin
                    dacq0_q <= 1'b0;
                    dacq1_q <= 1'b0;
                    if (owner_q) begin
                        if (cnt1_q != {CNT_W{1'b1}}) begin
                            cnt1_q <= cnt1_q + CNT_W'(1);
                        end
                    end else begin
                        if (cnt0_q != {CNT_W{1'b1}}) begin
                            cnt0_q <= cnt0_q + CNT_W'(1);
                        end
                    end
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign DAddress = daddr_q;
    assign Ddout    = ddout_q;
    assign wren     = wren_q;
    assign Ddin0    = ddin0_q;
    assign Ddin1    = ddin1_q;
    assign dacq0    = dacq0_q;
    assign dacq1    = dacq1_q;
    assign owner    = owner_q;
    assign acc_cnt0 = cnt0_q;
    assign acc_cnt1 = cnt1_q;

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single DRAM between two cores (core0, core1) in the dual-core build.
- Sits between each core's DAddress/Ddout/Mem_Ctrl/dacq/Ddin port and the DRAM address/data/wren/q port.
- Serialises one transaction at a time through a fixed 4-cycle sequence, with round-robin fairness.
- Keeps a saturating per-core access count for debug.

Parameters:
ADDR_W, 8, DRAM address width
DATA_W, 8, DRAM data width
CNT_W, 16, width of per-core access counters

Ports:
CLK  in  1  system clock (clkdiv output); all state changes on rising edge
rst  in  1  reset, asynchronous, active-low
Mem_Ctrl0  in  4  core0 memory control; bit0 = read request, bit1 = write request, bits 3:2 ignored
DAddress0  in  ADDR_W  core0 data address
Ddout0  in  DATA_W  core0 write data
Ddin0  out  DATA_W  core0 read data (registered)
dacq0  out  1  core0 transaction-complete strobe
Mem_Ctrl1  in  4  core1 memory control, same encoding
DAddress1  in  ADDR_W  core1 data address
Ddout1  in  DATA_W  core1 write data
Ddin1  out  DATA_W  core1 read data (registered)
dacq1  out  1  core1 transaction-complete strobe
DAddress  out  ADDR_W  to DRAM address
Ddout  out  DATA_W  to DRAM write data
wren  out  1  to DRAM write enable
Ddin  in  DATA_W  DRAM q; registered RAM, valid 1 cycle after address
owner  out  1  current or last granted core (debug)
acc_cnt0  out  CNT_W  completed core0 transactions, saturating
acc_cnt1  out  CNT_W  completed core1 transactions, saturating

Behaviour:
- Request: reqk = Mem_Ctrlk[0] | Mem_Ctrlk[1]. If both bits are set, the transaction is a write.
- A core holds its request, address and data stable until its dacqk. It drops the request in the cycle after dacqk.
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant that core.
  - Both request: grant the core that is not the last-served owner (round-robin).
  - On a grant: latch owner, latch the write flag (Mem_Ctrl_owner[1]), go to ADDR.
- ADDR:
  - DAddress/Ddout are driven from the owner's inputs.
  - wren = latched write flag (1 cycle only).
  - Go to DATA.
- DATA:
  - DAddress is still driven from the owner; wren = 0.
  - On the clock edge leaving DATA: if the transaction is a read, Ddin_owner <= Ddin. Writes do not load Ddin_owner.
  - dacq_owner <= 1; go to DONE.
- DONE:
  - dacq_owner = 1 for exactly this one cycle; read data is valid on Ddin_owner.
  - acc_cnt_owner increments, saturating at all-ones.
  - Go to IDLE unconditionally.
- Throughput and latency:
  - One transaction every 4 cycles.
  - Latency from request (sampled in IDLE) to dacq: 3 cycles.
  - Back-to-back requests from both cores alternate 0,1,0,1.
- Outputs outside ADDR/DATA:
  - DAddress = 0, Ddout = 0, wren = 0.
  - dacq0 = dacq1 = 0 except in DONE.
- Ddin0/Ddin1 hold their last loaded value indefinitely. The non-owner's Ddin never changes.
- Reset (asserted low, async, any state including mid-transaction):
  - FSM to IDLE; wren = 0, DAddress = 0, Ddout = 0 immediately.
  - dacq0 = dacq1 = 0, Ddin0 = Ddin1 = 0, acc_cnt0 = acc_cnt1 = 0.
  - owner = 1, so core0 wins the first simultaneous request.
  - An aborted write may or may not have reached the DRAM. The core is reset with the arbiter.
- A request that appears while another transaction is in flight waits. It is sampled on the next IDLE cycle.
- Bits 3:2 of Mem_Ctrl have no effect.

Test Plan:
- Reset, then core0 reads address 0x10 (DRAM model holds 0xA5) -> wren stays 0; DAddress = 0x10 in ADDR and DATA; dacq0 pulses 1 cycle at cycle 3; Ddin0 = 0xA5; acc_cnt0 = 1; Ddin1 unchanged (0).
- core1 writes 0x3C to 0x22 -> wren = 1 for exactly 1 cycle with DAddress = 0x22 and Ddout = 0x3C; dacq1 pulses; Ddin1 unchanged; a follow-up read of 0x22 by core0 returns 0x3C.
- Both cores hold read requests continuously after reset -> grants in order 0,1,0,1; a dacq every 4 cycles; never both dacq high together; each core's Ddin carries data from its own address.
- Assert rst during the ADDR cycle of a core0 write -> wren drops to 0 without waiting for a clock edge; FSM is in IDLE; no dacq0; counters read 0.
- Force acc_cnt0 to near saturation (CNT_W = 4 override, 16 core0 accesses) -> acc_cnt0 stops at 0xF; no wrap.
- Mem_Ctrl0 = 4'b1100 only -> no request; FSM stays in IDLE; no DRAM activity.
